// File: rtl/vga_timing_config_pkg.sv
// rtl/vga_timing_config_pkg.sv - shared mode codes, timing constants, state encoding and mode lookup
//
// Purpose : constants shared by the VGA timing configuration stage and its mode ROM.
// Contents: mode codes, per-mode H/V active and max counts, default widths,
//           FSM state encoding, and the mode lookup function.
package vga_timing_config_pkg;

  localparam int REZ_WIDTH_DEF     = 11;
  localparam int REZ_MAX_WIDTH_DEF = 11;
  localparam int MODE_WIDTH_DEF    = 3;

  localparam int unsigned MODE_640x480   = 0;
  localparam int unsigned MODE_800x600   = 1;
  localparam int unsigned MODE_1024x768  = 2;
  localparam int unsigned MODE_1280x1024 = 3;
  localparam int unsigned MODE_COUNT     = 4;

  // Max values are total-1 (the terminal count of each counter).
  localparam logic [10:0] H_ACTIV_640  = 11'd640;
  localparam logic [10:0] H_MAX_640    = 11'd799;
  localparam logic [10:0] V_ACTIV_640  = 11'd480;
  localparam logic [10:0] V_MAX_640    = 11'd524;

  localparam logic [10:0] H_ACTIV_800  = 11'd800;
  localparam logic [10:0] H_MAX_800    = 11'd1055;
  localparam logic [10:0] V_ACTIV_800  = 11'd600;
  localparam logic [10:0] V_MAX_800    = 11'd627;

  localparam logic [10:0] H_ACTIV_1024 = 11'd1024;
  localparam logic [10:0] H_MAX_1024   = 11'd1343;
  localparam logic [10:0] V_ACTIV_1024 = 11'd768;
  localparam logic [10:0] V_MAX_1024   = 11'd805;

  localparam logic [10:0] H_ACTIV_1280 = 11'd1280;
  localparam logic [10:0] H_MAX_1280   = 11'd1687;
  localparam logic [10:0] V_ACTIV_1280 = 11'd1024;
  localparam logic [10:0] V_MAX_1280   = 11'd1065;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [10:0] h_activ;
    logic [10:0] h_max;
    logic [10:0] v_activ;
    logic [10:0] v_max;
    logic        valid;
  } mode_entry_t;

  // Unknown codes return all-zero timing with valid=0.
  function automatic mode_entry_t mode_lookup(input int unsigned mode);
    mode_entry_t e;
    e = '0;
    case (mode)
      MODE_640x480:   e = '{H_ACTIV_640,  H_MAX_640,  V_ACTIV_640,  V_MAX_640,  1'b1};
      MODE_800x600:   e = '{H_ACTIV_800,  H_MAX_800,  V_ACTIV_800,  V_MAX_800,  1'b1};
      MODE_1024x768:  e = '{H_ACTIV_1024, H_MAX_1024, V_ACTIV_1024, V_MAX_1024, 1'b1};
      MODE_1280x1024: e = '{H_ACTIV_1280, H_MAX_1280, V_ACTIV_1280, V_MAX_1280, 1'b1};
      default:        e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// rtl/vga_mode_rom.sv - combinational mode code to H/V timing lookup
//
// Purpose : maps a mode code to its H/V active and max counts plus a valid flag.
// Ports   : i_mode    - mode code
//           o_h_activ - horizontal active count
//           o_h_max   - horizontal max count
//           o_v_activ - vertical active count
//           o_v_max   - vertical max count
//           o_valid   - code is a supported mode
module vga_mode_rom
  import vga_timing_config_pkg::*;
#(
  parameter int REZ_WIDTH     = REZ_WIDTH_DEF,
  parameter int REZ_MAX_WIDTH = REZ_MAX_WIDTH_DEF,
  parameter int MODE_WIDTH    = MODE_WIDTH_DEF
) (
  input  logic [MODE_WIDTH-1:0]    i_mode,
  output logic [REZ_WIDTH-1:0]     o_h_activ,
  output logic [REZ_MAX_WIDTH-1:0] o_h_max,
  output logic [REZ_WIDTH-1:0]     o_v_activ,
  output logic [REZ_MAX_WIDTH-1:0] o_v_max,
  output logic                     o_valid
);

  mode_entry_t w_entry;

  always_comb begin
    w_entry   = mode_lookup(32'(i_mode));
    o_h_activ = REZ_WIDTH'(w_entry.h_activ);
    o_h_max   = REZ_MAX_WIDTH'(w_entry.h_max);
    o_v_activ = REZ_WIDTH'(w_entry.v_activ);
    o_v_max   = REZ_MAX_WIDTH'(w_entry.v_max);
    o_valid   = w_entry.valid;
  end

endmodule

// File: rtl/vga_timing_config.sv
// rtl/vga_timing_config.sv - frame-synchronous VGA resolution configuration stage
//
// Purpose : accepts a mode request over valid/ready, validates it, and applies
//           it to the H/V counter timing outputs only at end-of-frame.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_cfg_valid/i_cfg_mode/o_cfg_ready - request handshake
//           o_cfg_ack  - one-cycle pulse, requested mode applied
//           o_cfg_err  - one-cycle pulse, request rejected
//           i_frame_end - end-of-frame pulse from the V counter
//           o_h_activ/o_h_max/o_v_activ/o_v_max - timing to H/V counters
//           o_mode_cur - mode currently applied
module vga_timing_config
  import vga_timing_config_pkg::*;
#(
  parameter int          REZ_WIDTH     = REZ_WIDTH_DEF,
  parameter int          REZ_MAX_WIDTH = REZ_MAX_WIDTH_DEF,
  parameter int          MODE_WIDTH    = MODE_WIDTH_DEF,
  parameter int unsigned RESET_MODE    = MODE_640x480
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cfg_valid,
  input  logic [MODE_WIDTH-1:0]    i_cfg_mode,
  output logic                     o_cfg_ready,
  output logic                     o_cfg_ack,
  output logic                     o_cfg_err,
  input  logic                     i_frame_end,
  output logic [REZ_WIDTH-1:0]     o_h_activ,
  output logic [REZ_MAX_WIDTH-1:0] o_h_max,
  output logic [REZ_WIDTH-1:0]     o_v_activ,
  output logic [REZ_MAX_WIDTH-1:0] o_v_max,
  output logic [MODE_WIDTH-1:0]    o_mode_cur
);

  localparam mode_entry_t RST_ENTRY = mode_lookup(RESET_MODE);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [MODE_WIDTH-1:0]    r_pending;
  logic [MODE_WIDTH-1:0]    r_mode_cur;
  logic [REZ_WIDTH-1:0]     r_h_activ;
  logic [REZ_MAX_WIDTH-1:0] r_h_max;
  logic [REZ_WIDTH-1:0]     r_v_activ;
  logic [REZ_MAX_WIDTH-1:0] r_v_max;
  logic                     r_ack;
  logic                     r_err;

  logic [MODE_WIDTH-1:0]    w_rom_addr;
  logic [REZ_WIDTH-1:0]     w_rom_h_activ;
  logic [REZ_MAX_WIDTH-1:0] w_rom_h_max;
  logic [REZ_WIDTH-1:0]     w_rom_v_activ;
  logic [REZ_MAX_WIDTH-1:0] w_rom_v_max;
  logic                     w_rom_valid;
  logic                     w_accept;
  logic                     w_reject;
  logic                     w_apply;

  // One ROM serves both jobs: in IDLE it validates the incoming request,
  // in PEND it supplies the values to load for the latched mode.
  assign w_rom_addr = (r_state == ST_PEND) ? r_pending : i_cfg_mode;

  vga_mode_rom #(
    .REZ_WIDTH     (REZ_WIDTH),
    .REZ_MAX_WIDTH (REZ_MAX_WIDTH),
    .MODE_WIDTH    (MODE_WIDTH)
  ) u_mode_rom (
    .i_mode    (w_rom_addr),
    .o_h_activ (w_rom_h_activ),
    .o_h_max   (w_rom_h_max),
    .o_v_activ (w_rom_v_activ),
    .o_v_max   (w_rom_v_max),
    .o_valid   (w_rom_valid)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic. Frame_end seen in IDLE (including the accept cycle)
  // is deliberately ignored so a frame is never started on half-loaded timing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_cfg_valid && w_rom_valid) w_state_nxt = ST_PEND;
      ST_PEND: if (i_frame_end)                w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_apply  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = i_cfg_valid &&  w_rom_valid;
        w_reject = i_cfg_valid && !w_rom_valid;
      end
      ST_PEND: w_apply = i_frame_end;
      default: ;
    endcase
  end

  // Datapath registers; every output comes straight from a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending  <= '0;
      r_mode_cur <= MODE_WIDTH'(RESET_MODE);
      r_h_activ  <= REZ_WIDTH'(RST_ENTRY.h_activ);
      r_h_max    <= REZ_MAX_WIDTH'(RST_ENTRY.h_max);
      r_v_activ  <= REZ_WIDTH'(RST_ENTRY.v_activ);
      r_v_max    <= REZ_MAX_WIDTH'(RST_ENTRY.v_max);
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= w_apply;
      r_err <= w_reject;
      if (w_accept) r_pending <= i_cfg_mode;
      if (w_apply) begin
        r_mode_cur <= r_pending;
        r_h_activ  <= w_rom_h_activ;
        r_h_max    <= w_rom_h_max;
        r_v_activ  <= w_rom_v_activ;
        r_v_max    <= w_rom_v_max;
      end
    end
  end

  assign o_cfg_ready = (r_state == ST_IDLE);
  assign o_cfg_ack   = r_ack;
  assign o_cfg_err   = r_err;
  assign o_h_activ   = r_h_activ;
  assign o_h_max     = r_h_max;
  assign o_v_activ   = r_v_activ;
  assign o_v_max     = r_v_max;
  assign o_mode_cur  = r_mode_cur;

endmodule

// File: tb/tb_vga_timing_config.sv
// tb/tb_vga_timing_config.sv - self-checking bench for vga_timing_config
module tb_vga_timing_config;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [2:0]  cfg_mode;
  logic        cfg_ready;
  logic        cfg_ack;
  logic        cfg_err;
  logic        frame_end;
  logic [10:0] h_activ;
  logic [10:0] h_max;
  logic [10:0] v_activ;
  logic [10:0] v_max;
  logic [2:0]  mode_cur;

  int total = 0;
  int bad   = 0;

  int H_ACT[4] = '{640, 800, 1024, 1280};
  int H_MX[4]  = '{799, 1055, 1343, 1687};
  int V_ACT[4] = '{480, 600, 768, 1024};
  int V_MX[4]  = '{524, 627, 805, 1065};

  typedef struct {
    bit v;
    int mode;
    bit fe;
    int cur;
    bit rdy;
    bit ack;
    bit err;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  bit m_busy;
  int m_pend;
  int m_cur;

  always #5 clk = ~clk;

  vga_timing_config dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_valid (cfg_valid),
    .i_cfg_mode  (cfg_mode),
    .o_cfg_ready (cfg_ready),
    .o_cfg_ack   (cfg_ack),
    .o_cfg_err   (cfg_err),
    .i_frame_end (frame_end),
    .o_h_activ   (h_activ),
    .o_h_max     (h_max),
    .o_v_activ   (v_activ),
    .o_v_max     (v_max),
    .o_mode_cur  (mode_cur)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input int cur, input bit rdy,
                           input bit ack, input bit err);
    chk({tag, ".mode_cur"}, int'(mode_cur), cur);
    chk({tag, ".h_activ"},  int'(h_activ),  H_ACT[cur]);
    chk({tag, ".h_max"},    int'(h_max),    H_MX[cur]);
    chk({tag, ".v_activ"},  int'(v_activ),  V_ACT[cur]);
    chk({tag, ".v_max"},    int'(v_max),    V_MX[cur]);
    chk({tag, ".ready"},    int'(cfg_ready), int'(rdy));
    chk({tag, ".ack"},      int'(cfg_ack),   int'(ack));
    chk({tag, ".err"},      int'(cfg_err),   int'(err));
  endtask

  // Apply inputs for one rising edge, then settle 1 time unit past it.
  task automatic drive(input bit v, input int m, input bit fe);
    cfg_valid = v;
    cfg_mode  = 3'(m);
    frame_end = fe;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 3'd0;
    frame_end = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_busy = 1'b0;
    m_pend = 0;
    m_cur  = 0;
  endtask

  function automatic vec_t mk(bit v, int mode, bit fe, int cur, bit rdy, bit ack, bit err);
    vec_t r;
    r.v = v; r.mode = mode; r.fe = fe; r.cur = cur; r.rdy = rdy; r.ack = ack; r.err = err;
    return r;
  endfunction

  initial begin
    // directed table (expected values hand-derived from the mode rules)
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0));  // accept mode 2
    for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 2, 1, 1, 0));  // apply on frame end
    vecs.push_back(mk(0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 2, 1, 0, 1));  // invalid code
    vecs.push_back(mk(0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(1, 3, 1, 2, 0, 0, 0));  // accept + frame end together
    vecs.push_back(mk(0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 1, 1, 0));  // applied on next frame end
    vecs.push_back(mk(1, 1, 0, 3, 0, 0, 0));  // accept mode 1
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0));  // held request ignored in PEND
    vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0));  // apply mode 1
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0));  // accepted in ack cycle
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0));  // apply mode 0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));  // same-mode request
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0));  // frame end in IDLE ignored
    vecs.push_back(mk(1, 7, 0, 0, 1, 0, 1));  // invalid code 7
    vecs.push_back(mk(1, 4, 0, 0, 1, 0, 1));  // invalid code 4

    do_reset();
    chk_state("reset", 0, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].mode, vecs[i].fe);
      chk_state($sformatf("vec%0d", i), vecs[i].cur, vecs[i].rdy, vecs[i].ack, vecs[i].err);
    end

    // reset while PEND discards the pending mode
    drive(1, 2, 0);
    drive(0, 0, 1);
    chk_state("rp.pre", 2, 1, 1, 0);
    drive(1, 1, 0);
    chk_state("rp.pend", 2, 0, 0, 0);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_state("rp.async", 0, 1, 0, 0);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 1);
    chk_state("rp.fe", 0, 1, 0, 0);
    drive(0, 0, 0);
    chk_state("rp.after", 0, 1, 0, 0);

    // randomized stimulus against the reference model
    do_reset();
    chk_state("rnd.reset", 0, 1, 0, 0);
    for (int n = 0; n < 600; n++) begin
      bit v;
      bit fe;
      int m;
      bit e_ack;
      bit e_err;
      v  = ($urandom_range(0, 1) == 1);
      m  = int'($urandom_range(0, 7));
      fe = ($urandom_range(0, 4) == 0);
      e_ack = 1'b0;
      e_err = 1'b0;
      if (!m_busy) begin
        if (v) begin
          if (m < 4) begin
            m_busy = 1'b1;
            m_pend = m;
          end else begin
            e_err = 1'b1;
          end
        end
      end else if (fe) begin
        m_cur  = m_pend;
        m_busy = 1'b0;
        e_ack  = 1'b1;
      end
      drive(v, m, fe);
      chk_state($sformatf("rnd%0d", n), m_cur, !m_busy, e_ack, e_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_config.md
Name: vga_timing_config

Overview:
- Upstream configuration stage for the VGA counters.
- Accepts a resolution-mode request over a valid/ready handshake, validates it, and holds the pending mode until the vertical counter reports end-of-frame.
- At end-of-frame it atomically loads the horizontal and vertical active/max values (60 Hz modes) that drive the H and V counter instances, so no frame is ever produced with mixed timing.

Parameters:
- REZ_WIDTH, 11, width of active-length outputs (H_activ, V_activ).
- REZ_MAX_WIDTH, 11, width of max-count outputs (H_max, V_max).
- MODE_WIDTH, 3, width of mode select; codes 0-3 valid, 4-7 rejected.
- RESET_MODE, 0, mode loaded on reset; must be a valid code.

Ports:
- Clk  in  1  system/pixel clock, all state on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Cfg_valid  in  1  request strobe; held until accepted.
- Cfg_mode  in  MODE_WIDTH  requested mode; stable while Cfg_valid=1.
- Cfg_ready  out  1  block can accept a request.
- Cfg_ack  out  1  one-cycle pulse: requested mode now applied.
- Cfg_err  out  1  one-cycle pulse: request rejected (invalid code).
- Frame_end  in  1  one-cycle pulse from V counter at V wrap (H and V both at max).
- H_activ  out  REZ_WIDTH  horizontal active count to H counter.
- H_max  out  REZ_MAX_WIDTH  horizontal max count (total-1).
- V_activ  out  REZ_WIDTH  vertical active count to V counter.
- V_max  out  REZ_MAX_WIDTH  vertical max count (total-1).
- Mode_cur  out  MODE_WIDTH  mode currently applied.

Behaviour:
- Mode table (activ/max), H then V:
  - 0 = 640x480: 640/799, 480/524.
  - 1 = 800x600: 800/1055, 600/627.
  - 2 = 1024x768: 1024/1343, 768/805.
  - 3 = 1280x1024: 1280/1687, 1024/1065.
- Reset (Rst=0, asynchronous):
  - State IDLE; Mode_cur=RESET_MODE; timing outputs = table[RESET_MODE].
  - Cfg_ready=1; Cfg_ack=0; Cfg_err=0; pending register cleared.
- FSM states IDLE and PEND.
- IDLE:
  - Cfg_ready=1.
  - Accept on edge with Cfg_valid=1.
  - Valid code: latch into pending register, go to PEND (Cfg_ready=0 next cycle).
  - Invalid code: Cfg_err=1 for the next cycle, stay IDLE, outputs unchanged.
  - Frame_end in IDLE is ignored.
- PEND:
  - Cfg_ready=0; further Cfg_valid is ignored (requester keeps holding it).
  - On edge with Frame_end=1: Mode_cur and all four timing outputs load from table[pending] in the same edge; Cfg_ack=1 for the following cycle; return to IDLE.
- Latency:
  - Outputs change exactly one edge after the Frame_end cycle, i.e. coincident with the counter wrap to 0.
  - Minimum accept-to-ack latency is 2 cycles.
- Simultaneous events:
  - Accept and Frame_end in the same cycle: that Frame_end is NOT used; apply waits for the next Frame_end.
- Same-mode request: full handshake and ack, outputs numerically unchanged.
- Back-to-back requests: the next request can be accepted in the cycle Cfg_ack is high (Cfg_ready=1 again).
- Outputs are registered only, with no combinational path from inputs to outputs.
- Cfg_ack and Cfg_err are never high in the same cycle.
- Reset mid-PEND discards the pending mode, returns all outputs to RESET_MODE, and generates no ack.

Decomposition:
- Shared include file holds:
  - mode code constants (MODE_640x480..MODE_1280x1024, MODE_COUNT=4);
  - per-mode H/V activ and max constants;
  - REZ_WIDTH/REZ_MAX_WIDTH defaults;
  - state encodings.
- One sub-module, vga_mode_rom: combinational mode → {H_activ,H_max,V_activ,V_max,valid} lookup. It is used both for validation at accept and for loading at apply.

Test Plan:
- Reset release → Mode_cur=0, H_activ=640, H_max=799, V_activ=480, V_max=524, Cfg_ready=1, no pulses.
- Cfg_valid with mode 2, Frame_end 10 cycles later → outputs 1024/1343/768/805 one edge after Frame_end; single Cfg_ack cycle; Cfg_ready back to 1.
- Cfg_mode=5 → Cfg_err pulses 1 cycle, no state change, outputs stay at mode 0, no Cfg_ack.
- Accept mode 3 with Frame_end in the same cycle → no change on that edge; apply on the next Frame_end to 1280/1687/1024/1065.
- Pull Rst low while in PEND with mode 1 → outputs return to mode 0 immediately; later Frame_end produces no ack and no change.
- Request mode 1 while in PEND → Cfg_ready=0, request held; accepted in the ack cycle; applied on the following Frame_end (800/1055/600/627).
